frame_energy_vad: RTL and testbench
===================================

Name: frame_energy_vad

Overview:
- Downstream consumer of the hamming window stage. Latches each windowed 128-sample frame and computes the frame energy (sum of squares) serially with a single multiplier.
- Tracks an adaptive noise floor and raises a voice-activity flag with hangover. The flag gates the later feature/classifier stages so they only run on speech frames.

Parameters:
N, 128, samples per frame; power of two, at least 4
WIDTH, 12, bits per signed two's-complement sample
NOISE_INIT, 1024, noise floor value after reset
ALPHA_SHIFT, 3, noise floor smoothing shift (alpha = 2^-ALPHA_SHIFT)
THRESH_SHIFT, 2, speech threshold = noise_floor << THRESH_SHIFT
HANGOVER, 8, frames the VAD stays high after the last raw speech frame
EW (localparam), 2*WIDTH+$clog2(N) = 31, energy width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
frame_in  in  [WIDTH-1:0] x [0:N-1]  windowed samples, signed
frame_valid  in  1  one-cycle pulse: frame_in is valid
busy  out  1  high while a frame is being processed
frame_dropped  out  1  one-cycle pulse: frame_valid arrived while busy
result_valid  out  1  one-cycle pulse: energy, vad, noise_floor updated
energy  out  EW  unsigned sum of squares of the last frame
noise_floor  out  EW  current noise floor estimate
vad  out  1  voice activity flag, held between results

Behaviour:
- Clock and reset: reset is rst, synchronous, active-high; clock is clk.
- Reset values: state=IDLE, busy=0, frame_dropped=0, result_valid=0, energy=0, vad=0, noise_floor=NOISE_INIT, hang_cnt=0, accumulator=0, index=0.
- FSM states: IDLE, ACCUM, DECIDE.
- IDLE:
  - When frame_valid=1 at edge E0: copy frame_in into the internal frame register, clear the accumulator, set index=0, busy=1, go to ACCUM.
- ACCUM:
  - Edges E1..EN add sample[index]^2 to the accumulator, then increment index.
  - The square is a signed WIDTH x WIDTH multiply; its result is non-negative and zero-extended to EW.
  - After index N-1, go to DECIDE.
- DECIDE (edge E(N+1)):
  - energy <= acc.
  - Raw speech test: acc > (noise_floor << THRESH_SHIFT), compared at EW+THRESH_SHIFT bits so there is no overflow.
  - If raw speech: hang_cnt <= HANGOVER; vad <= 1; noise_floor unchanged.
  - Otherwise: noise_floor <= noise_floor - (noise_floor >> ALPHA_SHIFT) + (acc >> ALPHA_SHIFT), computed in EW bits; cannot overflow.
  - Otherwise, if hang_cnt > 0: vad <= 1 and hang_cnt decrements.
  - Otherwise (not raw speech, hang_cnt = 0): vad <= 0.
  - result_valid <= 1 for exactly one cycle; busy <= 0; go to IDLE.
- Latency: result_valid is visible in the cycle after E(N+1), i.e. N+1 cycles after the frame_valid edge.
- Back-to-back frames: a new frame is accepted in IDLE on the cycle after result_valid's edge, at the earliest.
- Drops: frame_valid=1 while busy=1, including at the DECIDE edge, produces frame_dropped=1 for one cycle. The frame is ignored and the in-flight computation is unaffected.
- Input changes: frame_in may change freely after the E0 edge; only the latched copy is used.
- Energy bound: the worst case is all samples = -2^(WIDTH-1), giving N*2^(2*WIDTH-2) = 2^29 for the defaults. This fits EW; no saturation logic is needed.
- Reset mid-ACCUM or mid-DECIDE: abort to IDLE with reset values. No result_valid is emitted for the aborted frame.
- Outputs: energy, vad and noise_floor are registered and hold their value until the next DECIDE.

Test Plan:
1. Reset, then a frame of all zeros -> result_valid exactly 129 cycles after frame_valid; energy=0, vad=0, noise_floor=1024-128+0=896.
2. Frame of all +100 -> energy=1,280,000; vad=1 (> 896<<2); noise_floor unchanged at 896.
3. From reset, all samples = 6 -> energy=4608 > 4096, vad=1. Next frame all samples = 5 -> energy=3200, not raw speech; vad=1 via hangover, hang_cnt=7; noise_floor=1024-128+400=1296.
4. HANGOVER=2: one speech frame, then three zero frames -> vad sequence 1,1,1,0.
5. All samples = -2048 -> energy=536,870,912, vad=1; no overflow.
6. frame_valid pulsed at cycles E0+5 and E(N+1) of an active frame -> two frame_dropped pulses, first frame's energy correct. rst asserted mid-ACCUM -> no result_valid, and all outputs at reset values the next cycle.

Source files
------------

// File: rtl/frame_energy_vad.sv
// Frame energy voice-activity detector: latches a windowed frame, sums squares
// serially with one multiplier, then updates an adaptive noise floor and VAD flag.
module frame_energy_vad #(
  parameter int N            = 128,
  parameter int WIDTH        = 12,
  parameter int NOISE_INIT   = 1024,
  parameter int ALPHA_SHIFT  = 3,
  parameter int THRESH_SHIFT = 2,
  parameter int HANGOVER     = 8,
  localparam int EW          = 2*WIDTH + $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] frame_in [0:N-1],
  input  logic             frame_valid,
  output logic             busy,
  output logic             frame_dropped,
  output logic             result_valid,
  output logic [EW-1:0]    energy,
  output logic [EW-1:0]    noise_floor,
  output logic             vad
);

  localparam int IW = $clog2(N);
  localparam int HW = (HANGOVER < 1) ? 1 : $clog2(HANGOVER + 1);
  localparam int TW = EW + THRESH_SHIFT;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DECIDE
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [EW-1:0]     acc_q, acc_d;
  logic [HW-1:0]     hang_q, hang_d;
  logic              busy_q, busy_d;
  logic              drop_q, drop_d;
  logic              rv_q, rv_d;
  logic [EW-1:0]     energy_q, energy_d;
  logic [EW-1:0]     nf_q, nf_d;
  logic              vad_q, vad_d;

  logic [WIDTH-1:0]  frame_q [0:N-1];
  logic              frame_load;

  logic signed [WIDTH-1:0]   sample;
  logic signed [2*WIDTH-1:0] sq;
  logic [EW-1:0]             sq_ext;
  logic [TW-1:0]             thresh;
  logic [TW-1:0]             acc_wide;
  logic                      raw_speech;
  logic [EW-1:0]             nf_next;

  // Square of a signed sample is never negative, so plain zero-extension is exact.
  always_comb begin
    sample     = frame_q[idx_q];
    sq         = sample * sample;
    sq_ext     = {{(EW-2*WIDTH){1'b0}}, sq};
    thresh     = TW'(nf_q) << THRESH_SHIFT;
    acc_wide   = TW'(acc_q);
    raw_speech = acc_wide > thresh;
    nf_next    = nf_q - (nf_q >> ALPHA_SHIFT) + (acc_q >> ALPHA_SHIFT);
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    hang_d     = hang_q;
    busy_d     = busy_q;
    energy_d   = energy_q;
    nf_d       = nf_q;
    vad_d      = vad_q;
    rv_d       = 1'b0;
    drop_d     = frame_valid && busy_q;
    frame_load = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (frame_valid) begin
          frame_load = 1'b1;
          acc_d      = '0;
          idx_d      = '0;
          busy_d     = 1'b1;
          state_d    = S_ACCUM;
        end
      end
      S_ACCUM: begin
        acc_d = acc_q + sq_ext;
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(N - 1)) begin
          state_d = S_DECIDE;
        end
      end
      S_DECIDE: begin
        energy_d = acc_q;
        if (raw_speech) begin
          hang_d = HW'(HANGOVER);
          vad_d  = 1'b1;
        end else begin
          // Noise floor only tracks frames judged to be non-speech.
          nf_d = nf_next;
          if (hang_q != '0) begin
            vad_d  = 1'b1;
            hang_d = hang_q - 1'b1;
          end else begin
            vad_d = 1'b0;
          end
        end
        rv_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      hang_q   <= '0;
      busy_q   <= 1'b0;
      drop_q   <= 1'b0;
      rv_q     <= 1'b0;
      energy_q <= '0;
      nf_q     <= EW'(NOISE_INIT);
      vad_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      hang_q   <= hang_d;
      busy_q   <= busy_d;
      drop_q   <= drop_d;
      rv_q     <= rv_d;
      energy_q <= energy_d;
      nf_q     <= nf_d;
      vad_q    <= vad_d;
    end
  end

  // Frame storage needs no reset: it is always loaded before being read.
  always_ff @(posedge clk) begin
    if (frame_load) begin
      frame_q <= frame_in;
    end
  end

  assign busy          = busy_q;
  assign frame_dropped = drop_q;
  assign result_valid  = rv_q;
  assign energy        = energy_q;
  assign noise_floor   = nf_q;
  assign vad           = vad_q;

endmodule

// File: tb/tb_frame_energy_vad.sv
// Self-checking bench for frame_energy_vad against a plain-arithmetic reference model.
module tb_frame_energy_vad;

  localparam int N     = 128;
  localparam int WIDTH = 12;
  localparam int EW    = 31;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             fv, fv2;
  logic [WIDTH-1:0] frame_in [0:N-1];

  logic          busy, drop, rv, vad;
  logic [EW-1:0] energy, nf;
  logic          busy2, drop2, rv2, vad2;
  logic [EW-1:0] energy2, nf2;

  frame_energy_vad dut (
    .clk(clk), .rst(rst), .frame_in(frame_in), .frame_valid(fv),
    .busy(busy), .frame_dropped(drop), .result_valid(rv),
    .energy(energy), .noise_floor(nf), .vad(vad)
  );

  frame_energy_vad #(.HANGOVER(2)) dut2 (
    .clk(clk), .rst(rst), .frame_in(frame_in), .frame_valid(fv2),
    .busy(busy2), .frame_dropped(drop2), .result_valid(rv2),
    .energy(energy2), .noise_floor(nf2), .vad(vad2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int            cur [N];
  logic [EW-1:0] cap_e, cap_nf;
  logic          cap_vad;

  longint m_nf,  m2_nf;
  int     m_hang, m2_hang;
  bit     m_vad,  m2_vad;

  function automatic longint frame_energy();
    longint s = 0;
    for (int i = 0; i < N; i++) s += longint'(cur[i]) * longint'(cur[i]);
    return s;
  endfunction

  task automatic model_step(input int hmax, input longint e, inout longint nfl,
                            inout int hang, inout bit v);
    if (e > nfl * 4) begin
      hang = hmax;
      v    = 1'b1;
    end else begin
      nfl = nfl - nfl / 8 + e / 8;
      if (hang > 0) begin
        v = 1'b1;
        hang--;
      end else begin
        v = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    m_nf = 1024;  m_hang = 0;  m_vad = 1'b0;
    m2_nf = 1024; m2_hang = 0; m2_vad = 1'b0;
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < N; i++) cur[i] = v;
  endtask

  task automatic fill_random(input int amp);
    for (int i = 0; i < N; i++) cur[i] = int'($urandom_range(0, 2 * amp)) - amp;
  endtask

  task automatic scramble_input();
    for (int i = 0; i < N; i++) frame_in[i] = WIDTH'($urandom);
  endtask

  task automatic load_frame();
    for (int i = 0; i < N; i++) frame_in[i] = cur[i][WIDTH-1:0];
  endtask

  task automatic apply_reset();
    rst = 1'b1; fv = 1'b0; fv2 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // Called at #1 after a clock edge; returns latency in cycles or -1 on timeout.
  task automatic drive_frame(input int sel, output int latency);
    load_frame();
    if (sel == 0) fv = 1'b1; else fv2 = 1'b1;
    @(posedge clk);
    #1 fv = 1'b0; fv2 = 1'b0;
    scramble_input();
    latency = -1;
    for (int c = 1; c <= 2 * N; c++) begin
      @(posedge clk);
      #1;
      if (((sel == 0) ? rv : rv2) === 1'b1) begin
        latency = c;
        break;
      end
    end
    if (sel == 0) begin cap_e = energy;  cap_nf = nf;  cap_vad = vad;  end
    else          begin cap_e = energy2; cap_nf = nf2; cap_vad = vad2; end
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_checks++; if (drop !== 1'b0) begin n_fail++; $display("FAIL reset_dropped got=%b want=0", drop); end
    n_checks++; if (rv !== 1'b0) begin n_fail++; $display("FAIL reset_result_valid got=%b want=0", rv); end
    n_checks++; if (energy !== '0) begin n_fail++; $display("FAIL reset_energy got=%0d want=0", energy); end
    n_checks++; if (vad !== 1'b0) begin n_fail++; $display("FAIL reset_vad got=%b want=0", vad); end
    n_checks++; if (nf !== EW'(1024)) begin n_fail++; $display("FAIL reset_noise_floor got=%0d want=1024", nf); end
  endtask

  task automatic test_zero_then_loud();
    int lat;
    longint e;
    fill_const(0);
    e = frame_energy();
    drive_frame(0, lat);
    model_step(8, e, m_nf, m_hang, m_vad);
    n_checks++; if (lat != N + 1) begin n_fail++; $display("FAIL zero_latency got=%0d want=%0d", lat, N + 1); end
    n_checks++; if (cap_e !== EW'(e)) begin n_fail++; $display("FAIL zero_energy got=%0d want=%0d", cap_e, e); end
    n_checks++; if (cap_vad !== m_vad) begin n_fail++; $display("FAIL zero_vad got=%b want=%b", cap_vad, m_vad); end
    n_checks++; if (cap_nf !== EW'(896)) begin n_fail++; $display("FAIL zero_noise_floor got=%0d want=896", cap_nf); end
    fill_const(100);
    e = frame_energy();
    drive_frame(0, lat);
    model_step(8, e, m_nf, m_hang, m_vad);
    n_checks++; if (cap_e !== EW'(1280000)) begin n_fail++; $display("FAIL loud_energy got=%0d want=1280000", cap_e); end
    n_checks++; if (cap_vad !== 1'b1) begin n_fail++; $display("FAIL loud_vad got=%b want=1", cap_vad); end
    n_checks++; if (cap_nf !== EW'(m_nf)) begin n_fail++; $display("FAIL loud_noise_floor got=%0d want=%0d", cap_nf, m_nf); end
  endtask

  task automatic test_hangover();
    int lat;
    longint e;
    apply_reset();
    fill_const(6);
    e = frame_energy();
    drive_frame(0, lat);
    model_step(8, e, m_nf, m_hang, m_vad);
    n_checks++; if (cap_e !== EW'(4608)) begin n_fail++; $display("FAIL hang_speech_energy got=%0d want=4608", cap_e); end
    n_checks++; if (cap_vad !== 1'b1) begin n_fail++; $display("FAIL hang_speech_vad got=%b want=1", cap_vad); end
    fill_const(5);
    e = frame_energy();
    drive_frame(0, lat);
    model_step(8, e, m_nf, m_hang, m_vad);
    n_checks++; if (cap_e !== EW'(3200)) begin n_fail++; $display("FAIL hang_quiet_energy got=%0d want=3200", cap_e); end
    n_checks++; if (cap_vad !== 1'b1) begin n_fail++; $display("FAIL hang_quiet_vad got=%b want=1", cap_vad); end
    n_checks++; if (cap_nf !== EW'(1296)) begin n_fail++; $display("FAIL hang_quiet_noise_floor got=%0d want=1296", cap_nf); end
  endtask

  task automatic test_hangover_short();
    int lat;
    longint e;
    bit want [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      fill_const((k == 0) ? 100 : 0);
      e = frame_energy();
      drive_frame(1, lat);
      model_step(2, e, m2_nf, m2_hang, m2_vad);
      n_checks++; if (cap_vad !== want[k]) begin n_fail++; $display("FAIL short_hang_vad[%0d] got=%b want=%b", k, cap_vad, want[k]); end
      n_checks++; if (cap_nf !== EW'(m2_nf)) begin n_fail++; $display("FAIL short_hang_nf[%0d] got=%0d want=%0d", k, cap_nf, m2_nf); end
    end
  endtask

  task automatic test_full_scale();
    int lat;
    longint e;
    fill_const(-2048);
    e = frame_energy();
    drive_frame(0, lat);
    model_step(8, e, m_nf, m_hang, m_vad);
    n_checks++; if (lat != N + 1) begin n_fail++; $display("FAIL full_latency got=%0d want=%0d", lat, N + 1); end
    n_checks++; if (cap_e !== EW'(536870912)) begin n_fail++; $display("FAIL full_energy got=%0d want=536870912", cap_e); end
    n_checks++; if (cap_vad !== 1'b1) begin n_fail++; $display("FAIL full_vad got=%b want=1", cap_vad); end
    n_checks++; if (cap_nf !== EW'(m_nf)) begin n_fail++; $display("FAIL full_noise_floor got=%0d want=%0d", cap_nf, m_nf); end
  endtask

  // Frames are issued back-to-back at the earliest acceptance cycle.
  task automatic test_random();
    int lat;
    longint e;
    int amps [7] = '{0, 3, 5, 8, 20, 100, 2047};
    for (int f = 0; f < 24; f++) begin
      fill_random(amps[$urandom_range(0, 6)]);
      e = frame_energy();
      drive_frame(0, lat);
      model_step(8, e, m_nf, m_hang, m_vad);
      n_checks++; if (lat != N + 1) begin n_fail++; $display("FAIL rand_latency[%0d] got=%0d want=%0d", f, lat, N + 1); end
      n_checks++; if (cap_e !== EW'(e)) begin n_fail++; $display("FAIL rand_energy[%0d] got=%0d want=%0d", f, cap_e, e); end
      n_checks++; if (cap_vad !== m_vad) begin n_fail++; $display("FAIL rand_vad[%0d] got=%b want=%b", f, cap_vad, m_vad); end
      n_checks++; if (cap_nf !== EW'(m_nf)) begin n_fail++; $display("FAIL rand_noise_floor[%0d] got=%0d want=%0d", f, cap_nf, m_nf); end
    end
  endtask

  task automatic test_drops();
    longint e;
    fill_random(100);
    e = frame_energy();
    load_frame();
    fv = 1'b1;
    @(posedge clk);
    #1 fv = 1'b0;
    scramble_input();
    repeat (4) begin @(posedge clk); #1; end
    fv = 1'b1;
    @(posedge clk);
    #1 fv = 1'b0;
    n_checks++; if (drop !== 1'b1) begin n_fail++; $display("FAIL drop_accum_pulse got=%b want=1", drop); end
    @(posedge clk);
    #1;
    n_checks++; if (drop !== 1'b0) begin n_fail++; $display("FAIL drop_pulse_width got=%b want=0", drop); end
    repeat (N - 6) begin @(posedge clk); #1; end
    n_checks++; if (rv !== 1'b0) begin n_fail++; $display("FAIL drop_early_result got=%b want=0", rv); end
    scramble_input();
    fv = 1'b1;
    @(posedge clk);
    #1 fv = 1'b0;
    model_step(8, e, m_nf, m_hang, m_vad);
    n_checks++; if (drop !== 1'b1) begin n_fail++; $display("FAIL drop_decide_pulse got=%b want=1", drop); end
    n_checks++; if (rv !== 1'b1) begin n_fail++; $display("FAIL drop_result_valid got=%b want=1", rv); end
    n_checks++; if (energy !== EW'(e)) begin n_fail++; $display("FAIL drop_energy got=%0d want=%0d", energy, e); end
    n_checks++; if (vad !== m_vad) begin n_fail++; $display("FAIL drop_vad got=%b want=%b", vad, m_vad); end
    @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_not_started got=%b want=0", busy); end
    n_checks++; if (rv !== 1'b0) begin n_fail++; $display("FAIL drop_rv_single got=%b want=0", rv); end
  endtask

  task automatic test_reset_mid_accum();
    int lat;
    int seen;
    longint e;
    fill_random(50);
    load_frame();
    fv = 1'b1;
    @(posedge clk);
    #1 fv = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b want=0", busy); end
    n_checks++; if (energy !== '0) begin n_fail++; $display("FAIL abort_energy got=%0d want=0", energy); end
    n_checks++; if (vad !== 1'b0) begin n_fail++; $display("FAIL abort_vad got=%b want=0", vad); end
    n_checks++; if (nf !== EW'(1024)) begin n_fail++; $display("FAIL abort_noise_floor got=%0d want=1024", nf); end
    seen = 0;
    for (int c = 0; c < N + 5; c++) begin
      @(posedge clk);
      #1;
      if (rv === 1'b1) seen++;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL abort_no_result got=%0d want=0", seen); end
    fill_random(20);
    e = frame_energy();
    drive_frame(0, lat);
    model_step(8, e, m_nf, m_hang, m_vad);
    n_checks++; if (cap_e !== EW'(e)) begin n_fail++; $display("FAIL abort_recover_energy got=%0d want=%0d", cap_e, e); end
    n_checks++; if (cap_nf !== EW'(m_nf)) begin n_fail++; $display("FAIL abort_recover_nf got=%0d want=%0d", cap_nf, m_nf); end
  endtask

  initial begin
    rst = 1'b1;
    fv  = 1'b0;
    fv2 = 1'b0;
    for (int i = 0; i < N; i++) frame_in[i] = '0;
    test_reset();
    test_zero_then_loud();
    test_hangover();
    test_hangover_short();
    test_full_scale();
    test_random();
    test_drops();
    test_reset_mid_accum();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
